rv32_mhart_regfile: RTL and testbench

Parametrised multi-HART integer register file for the rv32_cpu core, successor to the single-HART RV32I register file. Holds one 32-entry (RV32I) or 16-entry (RV32E) bank per HART, with two registered read ports, one write port, and two-deep write-to-read forwarding. An optional hardware clear sequencer zeroes every bank after reset. The block sits between the decoder, which supplies the indices, and the ALU/writeback stage, which consumes rs1/rs2 and supplies new_rd.

---
 rtl/rv32_mhart_regfile_if.sv | 27 ++
 rtl/rv32_mhart_regfile.sv | 92 +++++++++
 tb/tb_rv32_mhart_regfile.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rv32_mhart_regfile_if.sv
// rv32_mhart_regfile_if: decoder/writeback-side signal bundle of the multi-HART register file
interface rv32_mhart_regfile_if #(
  parameter int LOG2_HARTS = 0,
  parameter int DATA_WIDTH = 32
);
  localparam int HW = LOG2_HARTS > 0 ? LOG2_HARTS : 1;
  logic [HW-1:0]         rs_hart;
  logic [4:0]            rs1_idx;
  logic [4:0]            rs2_idx;
  logic [HW-1:0]         rd_hart;
  logic [4:0]            rd_idx;
  logic                  rd_wr;
  logic [DATA_WIDTH-1:0] new_rd;
  logic                  stall;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;
  logic                  illegal_idx;
  logic                  init_busy;
  modport master (
    output rs_hart, rs1_idx, rs2_idx, rd_hart, rd_idx, rd_wr, new_rd, stall,
    input  rs1, rs2, illegal_idx, init_busy
  );
  modport slave (
    input  rs_hart, rs1_idx, rs2_idx, rd_hart, rd_idx, rd_wr, new_rd, stall,
    output rs1, rs2, illegal_idx, init_busy
  );
endinterface

// File: rtl/rv32_mhart_regfile.sv
// rv32_mhart_regfile: 2R1W multi-HART RV32I/E register file with two-deep write forwarding.
// Define RV32_REGFILE_HW_CLEAR_EN to add the post-reset clear sequencer.
module rv32_mhart_regfile #(
  parameter int LOG2_HARTS           = 0,
  parameter int LOG2_REGFILE_ENTRIES = 5,
  parameter int DATA_WIDTH           = 32
) (
  input logic                 clk,
  input logic                 reset_n,
  rv32_mhart_regfile_if.slave io_rf
);
  localparam int AW = LOG2_HARTS + LOG2_REGFILE_ENTRIES;
  localparam int HW = LOG2_HARTS > 0 ? LOG2_HARTS : 1;
  logic [DATA_WIDTH-1:0] r_mem [1<<AW];
  logic                  w_busy, w_clr_we, w_wq;
  logic [AW-1:0]         w_clr_addr, w_wr_addr, w_rs1_addr, w_rs2_addr;
  logic [AW-1:0]         r_rs1_addr, r_rs2_addr, r_wq_addr;
  logic [DATA_WIDTH-1:0] r_rs1_q, r_rs2_q, r_wq_data;
  logic                  r_rs1_zero, r_rs2_zero, r_wq_prev, r_illegal;
  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < 6'(1 << LOG2_REGFILE_ENTRIES);
  endfunction
  // with a single HART the shifted hart bits fall off the top of the address
  function automatic logic [AW-1:0] addr(input logic [HW-1:0] hart, input logic [4:0] idx);
    return (AW'(hart) << LOG2_REGFILE_ENTRIES) | AW'(idx);
  endfunction
`ifdef RV32_REGFILE_HW_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == CLEAR) begin
      w_cnt_nxt   = r_cnt + 1'b1;
      w_state_nxt = &r_cnt ? READY : CLEAR;
    end
  end
  assign w_busy     = r_state == CLEAR;
  assign w_clr_we   = w_busy;
  assign w_clr_addr = r_cnt;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif
  assign w_wr_addr  = addr(io_rf.rd_hart, io_rf.rd_idx);
  assign w_rs1_addr = addr(io_rf.rs_hart, io_rf.rs1_idx);
  assign w_rs2_addr = addr(io_rf.rs_hart, io_rf.rs2_idx);
  assign w_wq = io_rf.rd_wr & ~io_rf.stall & ~w_busy & (io_rf.rd_idx != 5'd0) & in_range(io_rf.rd_idx);
  // synchronous array read misses a same-edge write; r_wq_* covers that case
  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[w_clr_addr] <= '0;
    else if (w_wq) r_mem[w_wr_addr] <= io_rf.new_rd;
    r_rs1_q    <= r_mem[w_rs1_addr];
    r_rs2_q    <= r_mem[w_rs2_addr];
    r_rs1_addr <= w_rs1_addr;
    r_rs2_addr <= w_rs2_addr;
    r_wq_addr  <= w_wr_addr;
    r_wq_data  <= io_rf.new_rd;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rs1_zero <= 1'b1;
      r_rs2_zero <= 1'b1;
      r_wq_prev  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_rs1_zero <= (io_rf.rs1_idx == 5'd0) | ~in_range(io_rf.rs1_idx) | w_busy;
      r_rs2_zero <= (io_rf.rs2_idx == 5'd0) | ~in_range(io_rf.rs2_idx) | w_busy;
      r_wq_prev  <= w_wq;
      r_illegal  <= ~in_range(io_rf.rs1_idx) | ~in_range(io_rf.rs2_idx) | (io_rf.rd_wr & ~in_range(io_rf.rd_idx));
    end
  end
  assign io_rf.rs1 = r_rs1_zero ? '0 :
                     (w_wq && w_wr_addr == r_rs1_addr) ? io_rf.new_rd :
                     (r_wq_prev && r_wq_addr == r_rs1_addr) ? r_wq_data : r_rs1_q;
  assign io_rf.rs2 = r_rs2_zero ? '0 :
                     (w_wq && w_wr_addr == r_rs2_addr) ? io_rf.new_rd :
                     (r_wq_prev && r_wq_addr == r_rs2_addr) ? r_wq_data : r_rs2_q;
  assign io_rf.illegal_idx = r_illegal;
  assign io_rf.init_busy   = w_busy;
endmodule

// File: tb/tb_rv32_mhart_regfile.sv
// tb_rv32_mhart_regfile: directed checks on a 4-HART RV32I instance and a 1-HART RV32E instance
module tb_rv32_mhart_regfile;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  always #5 clk = ~clk;
  rv32_mhart_regfile_if #(.LOG2_HARTS(2), .DATA_WIDTH(32)) m ();
  rv32_mhart_regfile_if #(.LOG2_HARTS(0), .DATA_WIDTH(32)) e ();
  rv32_mhart_regfile #(.LOG2_HARTS(2), .LOG2_REGFILE_ENTRIES(5), .DATA_WIDTH(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .io_rf(m)
  );
  rv32_mhart_regfile #(.LOG2_HARTS(0), .LOG2_REGFILE_ENTRIES(4), .DATA_WIDTH(32)) u_dut_e (
    .clk(clk), .reset_n(reset_n), .io_rf(e)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] h, input logic [4:0] i, input logic [31:0] d);
    m.rd_hart = h;
    m.rd_idx  = i;
    m.new_rd  = d;
    m.rd_wr   = 1'b1;
    tick();
    m.rd_wr   = 1'b0;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (m.rs1 !== 32'h0) begin n_errors++; $display("FAIL reset_rs1: got %h want 0", m.rs1); end
    n_checks++; if (m.rs2 !== 32'h0) begin n_errors++; $display("FAIL reset_rs2: got %h want 0", m.rs2); end
    n_checks++; if (m.illegal_idx !== 1'b0) begin n_errors++; $display("FAIL reset_illegal: got %b want 0", m.illegal_idx); end
`ifdef RV32_REGFILE_HW_CLEAR_EN
    n_checks++; if (m.init_busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b want 1", m.init_busy); end
`else
    n_checks++; if (m.init_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", m.init_busy); end
`endif
  endtask
`ifdef RV32_REGFILE_HW_CLEAR_EN
  task automatic test_clear();
    int n = 0;
    reset_n = 1'b1;
    while (m.init_busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    n_checks++; if (n != 128) begin n_errors++; $display("FAIL clear_cycles: got %0d want 128", n); end
    n_checks++; if (e.init_busy !== 1'b0) begin n_errors++; $display("FAIL clear_e_busy: got %b want 0", e.init_busy); end
    for (int h = 0; h < 4; h++) begin
      for (int i = 0; i < 32; i++) begin
        m.rs_hart = 2'(h);
        m.rs1_idx = 5'(i);
        m.rs2_idx = 5'(31 - i);
        tick();
        n_checks++; if (m.rs1 !== 32'h0) begin n_errors++; $display("FAIL clear_rs1 h%0d x%0d: got %h want 0", h, i, m.rs1); end
        n_checks++; if (m.rs2 !== 32'h0) begin n_errors++; $display("FAIL clear_rs2 h%0d x%0d: got %h want 0", h, 31 - i, m.rs2); end
      end
    end
  endtask
`else
  task automatic test_clear();
    reset_n = 1'b1;
    n_checks++; if (m.init_busy !== 1'b0) begin n_errors++; $display("FAIL noclear_busy: got %b want 0", m.init_busy); end
    wr(2'd2, 5'd4, 32'h0000_4444);
    m.rs_hart = 2'd2;
    m.rs1_idx = 5'd4;
    tick();
    n_checks++; if (m.rs1 !== 32'h0000_4444) begin n_errors++; $display("FAIL noclear_first_write: got %h want 00004444", m.rs1); end
  endtask
`endif
  task automatic test_forward();
    m.rd_hart = 2'd1; m.rd_idx = 5'd5; m.new_rd = 32'hDEAD_BEEF; m.rd_wr = 1'b1;
    m.rs_hart = 2'd1; m.rs1_idx = 5'd5;
    tick();
    m.new_rd = 32'h1234_5678;
    #1;
    n_checks++; if (m.rs1 !== 32'h1234_5678) begin n_errors++; $display("FAIL fwd_same_cycle: got %h want 12345678", m.rs1); end
    tick();
    m.new_rd = 32'hDEAD_BEEF;
    tick();
    m.rd_wr = 1'b0;
    #1;
    n_checks++; if (m.rs1 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL fwd_prev_cycle: got %h want deadbeef", m.rs1); end
    tick();
    n_checks++; if (m.rs1 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL fwd_array: got %h want deadbeef", m.rs1); end
    n_checks++; if (m.illegal_idx !== 1'b0) begin n_errors++; $display("FAIL fwd_illegal: got %b want 0", m.illegal_idx); end
  endtask
  task automatic test_isolation();
    wr(2'd3, 5'd7, 32'h0);
    m.rs_hart = 2'd3; m.rs2_idx = 5'd7;
    m.rd_hart = 2'd0; m.rd_idx = 5'd7; m.new_rd = 32'hA5A5_A5A5; m.rd_wr = 1'b1;
    tick();
    #1;
    n_checks++; if (m.rs2 !== 32'h0) begin n_errors++; $display("FAIL iso_comb_fwd: got %h want 0", m.rs2); end
    tick();
    m.rd_wr = 1'b0;
    #1;
    n_checks++; if (m.rs2 !== 32'h0) begin n_errors++; $display("FAIL iso_prev_fwd: got %h want 0", m.rs2); end
    m.rs_hart = 2'd0;
    tick();
    n_checks++; if (m.rs2 !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL iso_own_hart: got %h want a5a5a5a5", m.rs2); end
  endtask
  task automatic test_x0_stall();
    wr(2'd0, 5'd3, 32'h0000_0033);
    m.rs_hart = 2'd0; m.rs1_idx = 5'd0;
    m.rd_hart = 2'd0; m.rd_idx = 5'd0; m.new_rd = 32'hFFFF_FFFF; m.rd_wr = 1'b1;
    tick();
    tick();
    n_checks++; if (m.rs1 !== 32'h0) begin n_errors++; $display("FAIL x0_write: got %h want 0", m.rs1); end
    m.stall = 1'b1; m.rd_idx = 5'd3; m.new_rd = 32'h1; m.rs1_idx = 5'd3;
    tick();
    n_checks++; if (m.rs1 !== 32'h0000_0033) begin n_errors++; $display("FAIL stall_comb_fwd: got %h want 00000033", m.rs1); end
    tick();
    n_checks++; if (m.rs1 !== 32'h0000_0033) begin n_errors++; $display("FAIL stall_prev_fwd: got %h want 00000033", m.rs1); end
    m.stall = 1'b0; m.rd_wr = 1'b0;
    tick();
    n_checks++; if (m.rs1 !== 32'h0000_0033) begin n_errors++; $display("FAIL stall_array: got %h want 00000033", m.rs1); end
  endtask
  task automatic test_rv32e();
    e.rd_hart = 1'b0; e.rd_idx = 5'd1; e.new_rd = 32'h0000_0011; e.rd_wr = 1'b1;
    tick();
    e.rd_wr = 1'b0; e.rs1_idx = 5'd20;
    tick();
    n_checks++; if (e.rs1 !== 32'h0) begin n_errors++; $display("FAIL e_oob_read: got %h want 0", e.rs1); end
    n_checks++; if (e.illegal_idx !== 1'b1) begin n_errors++; $display("FAIL e_illegal_set: got %b want 1", e.illegal_idx); end
    e.rs1_idx = 5'd1;
    tick();
    n_checks++; if (e.illegal_idx !== 1'b0) begin n_errors++; $display("FAIL e_illegal_pulse: got %b want 0", e.illegal_idx); end
    n_checks++; if (e.rs1 !== 32'h0000_0011) begin n_errors++; $display("FAIL e_x1_read: got %h want 00000011", e.rs1); end
    e.rd_idx = 5'd17; e.new_rd = 32'h0000_0099; e.rd_wr = 1'b1; e.rs_hart = 1'b1;
    tick();
    n_checks++; if (e.rs1 !== 32'h0000_0011) begin n_errors++; $display("FAIL e_alias_comb: got %h want 00000011", e.rs1); end
    n_checks++; if (e.illegal_idx !== 1'b1) begin n_errors++; $display("FAIL e_illegal_rd: got %b want 1", e.illegal_idx); end
    e.rd_wr = 1'b0;
    tick();
    n_checks++; if (e.rs1 !== 32'h0000_0011) begin n_errors++; $display("FAIL e_alias_array: got %h want 00000011", e.rs1); end
    n_checks++; if (e.illegal_idx !== 1'b0) begin n_errors++; $display("FAIL e_illegal_clr: got %b want 0", e.illegal_idx); end
  endtask
`ifdef RV32_REGFILE_HW_CLEAR_EN
  task automatic test_reset_mid_clear();
    int n = 0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    n_checks++; if (m.init_busy !== 1'b1) begin n_errors++; $display("FAIL midclr_busy: got %b want 1", m.init_busy); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    while (m.init_busy === 1'b1 && n < 1000) begin
      m.rd_hart = 2'd0; m.rd_idx = 5'd9; m.new_rd = 32'hCAFE_F00D; m.rd_wr = (n == 100);
      tick();
      n++;
    end
    m.rd_wr = 1'b0;
    n_checks++; if (n != 128) begin n_errors++; $display("FAIL midclr_cycles: got %0d want 128", n); end
    m.rs_hart = 2'd0; m.rs1_idx = 5'd9;
    tick();
    n_checks++; if (m.rs1 !== 32'h0) begin n_errors++; $display("FAIL midclr_write_dropped: got %h want 0", m.rs1); end
  endtask
`endif
  initial begin
    {m.rs_hart, m.rs1_idx, m.rs2_idx, m.rd_hart, m.rd_idx, m.rd_wr, m.new_rd, m.stall} = '0;
    {e.rs_hart, e.rs1_idx, e.rs2_idx, e.rd_hart, e.rd_idx, e.rd_wr, e.new_rd, e.stall} = '0;
    test_reset();
    test_clear();
    test_forward();
    test_isolation();
    test_x0_stall();
    test_rv32e();
`ifdef RV32_REGFILE_HW_CLEAR_EN
    test_reset_mid_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
